// File: rtl/barrett_param_gen_pkg.sv
// barrett_param_gen_pkg
// Shared definitions for the Barrett parameter generator and the
// Vedic_Barrett datapath it feeds.
//   - Q_W_DEF  : modulus width (matches the a/b/q width of Vedic_Barrett)
//   - K_W_DEF  : width of k; 2^K_W_DEF must exceed Q_W_DEF
//   - MU_W_DEF : width of mu (see note below)
//   - state_t  : 2-bit FSM encoding, IDLE=0, LEN=1, DIV=2, DONE=3
package barrett_param_gen_pkg;

    localparam int Q_W_DEF = 64;
    localparam int K_W_DEF = 8;

    // For q in [2^(k-1), 2^k) the quotient 2^(2k)/q lies in (2^k, 2^(k+1)].
    // The top value 2^(Q_W+1) occurs for q = 2^(Q_W-1), so mu needs Q_W+2 bits.
    localparam int MU_W_DEF = Q_W_DEF + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/barrett_param_gen_if.sv
// barrett_param_gen_if
// Request/response bundle of the Barrett parameter generator.
//   Request  : in_valid, in_ready, q
//   Response : out_valid, out_ready, k, mu, err
// Modports: slave = the generator, master = the requester/consumer.
interface barrett_param_gen_if
    import barrett_param_gen_pkg::*;
#(
    parameter int Q_W  = Q_W_DEF,
    parameter int MU_W = MU_W_DEF,
    parameter int K_W  = K_W_DEF
);

    logic            in_valid;
    logic            in_ready;
    logic [Q_W-1:0]  q;
    logic            out_valid;
    logic            out_ready;
    logic [K_W-1:0]  k;
    logic [MU_W-1:0] mu;
    logic            err;

    modport slave (
        input  in_valid,
        output in_ready,
        input  q,
        output out_valid,
        input  out_ready,
        output k,
        output mu,
        output err
    );

    modport master (
        output in_valid,
        input  in_ready,
        output q,
        input  out_valid,
        output out_ready,
        input  k,
        input  mu,
        input  err
    );

endinterface

// File: rtl/barrett_param_gen_msb_index.sv
// msb_index
// Combinational priority encoder returning the bit length of its input:
// index of the highest set bit plus one, or 0 for an all-zero input.
//   i_value : Q_W-bit operand
//   o_len   : K_W-bit bit length
module msb_index
    import barrett_param_gen_pkg::*;
#(
    parameter int Q_W = Q_W_DEF,
    parameter int K_W = K_W_DEF
) (
    input  logic [Q_W-1:0] i_value,
    output logic [K_W-1:0] o_len
);

    // Ascending scan so the highest set bit is the last one to write.
    always_comb begin
        o_len = '0;
        for (int i = 0; i < Q_W; i++) begin
            if (i_value[i]) begin
                o_len = K_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/barrett_param_gen.sv
// barrett_param_gen
// Sequential precompute engine for the Barrett datapath. For a modulus q it
// produces k = bit length of q and mu = floor(2^(2k)/q) using a restoring
// divider that retires one quotient bit per cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of barrett_param_gen_if (in_valid/in_ready/q request,
//           out_valid/out_ready/k/mu/err response, err flags q == 0)
// Latency from the accepting edge E0 to out_valid is 2k+2 edges (2 for q==0).
module barrett_param_gen
    import barrett_param_gen_pkg::*;
#(
    parameter int Q_W  = Q_W_DEF,
    parameter int MU_W = MU_W_DEF,
    parameter int K_W  = K_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    barrett_param_gen_if.slave  bus
);

    localparam int CNT_W = K_W + 1;

    state_t            r_state;
    state_t            w_stateNext;
    logic [Q_W-1:0]    r_q;
    logic [K_W-1:0]    r_k;
    logic [MU_W-1:0]   r_mu;
    logic              r_err;
    logic [Q_W-1:0]    r_rem;
    logic [CNT_W-1:0]  r_cnt;

    logic [K_W-1:0]    w_len;
    logic              w_accept;
    logic              w_dBit;
    logic [Q_W:0]      w_t;
    logic [Q_W:0]      w_diff;
    logic              w_borrow;

    msb_index #(
        .Q_W (Q_W),
        .K_W (K_W)
    ) u_msbIndex (
        .i_value (r_q),
        .o_len   (w_len)
    );

    assign w_accept = bus.in_valid && (r_state == IDLE);

    // The dividend 2^(2k) is a single 1 followed by 2k zeros, so the only
    // nonzero dividend bit is fed on the first DIV step.
    assign w_dBit = (r_cnt == {r_k, 1'b0});
    assign w_t    = {r_rem, w_dBit};

    // rem < q gives t <= 2q-1, so t-q lies in [-q, q-1] and fits a
    // (Q_W+1)-bit two's complement result: the sign bit is the borrow and
    // doubles as the "t < q" compare.
    assign w_diff   = w_t - {1'b0, r_q};
    assign w_borrow = w_diff[Q_W];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. q==0 still takes one DIV step (cnt starts at 0) so
    // its latency follows the same 2k+2 rule as every other modulus.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: if (w_accept) w_stateNext = LEN;
            LEN:  w_stateNext = DIV;
            DIV:  if (r_cnt == '0) w_stateNext = DONE;
            DONE: if (bus.out_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Datapath. Results are left untouched in DONE and IDLE so outputs stay
    // frozen under backpressure. With err set the divider only counts down;
    // mu stays at zero. Quotient bits pushed out of the MSB of mu are zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_k   <= '0;
            r_mu  <= '0;
            r_err <= 1'b0;
            r_rem <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q <= bus.q;
                    end
                end
                LEN: begin
                    r_k   <= w_len;
                    r_cnt <= {w_len, 1'b0};
                    r_rem <= '0;
                    r_mu  <= '0;
                    r_err <= (r_q == '0);
                end
                DIV: begin
                    if (!r_err) begin
                        r_rem <= w_borrow ? w_t[Q_W-1:0] : w_diff[Q_W-1:0];
                        r_mu  <= {r_mu[MU_W-2:0], ~w_borrow};
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.k         = r_k;
    assign bus.mu        = r_mu;
    assign bus.err       = r_err;

endmodule
